beep_tone_gen: RTL and testbench

//  Note-driven tone generator directly upstream of the PWM DAC.
//  - Accepts one note per valid/ready handshake: phase increment, duration, waveform, volume.
//  - Emits 8-bit unsigned samples at pwmclk/CLK_DIV (44 kHz at 110 MHz, CLK_DIV=2500).
//  - Drives the DAC's sample and enable inputs.

---
 rtl/beep_tone_gen.sv | 147 ++++++++++++++
 tb/tb_beep_tone_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_tone_gen.sv
// rtl/beep_tone_gen.sv - note-driven tone generator feeding the PWM DAC
// Takes one note per handshake and emits CLK_DIV-spaced 8-bit samples for its duration.
module beep_tone_gen #(
   parameter int CLK_DIV = 2500,
   parameter int PHASE_W = 16,
   parameter int DUR_W   = 16
) (
   input  logic               pwmclk,
   input  logic               rst_n,
   input  logic               note_valid,
   output logic               note_ready,
   input  logic [PHASE_W-1:0] note_inc,
   input  logic [DUR_W-1:0]   note_dur,
   input  logic [1:0]         note_wave,
   input  logic [2:0]         note_vol,
   output logic [7:0]         sample,
   output logic               sample_stb,
   output logic               enable
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [7:0] MIDSCALE = 8'd128;

   // ST_LAST keeps enable high for the cycle that shows the final strobe.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_LAST = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [PHASE_W-1:0]   inc_q, inc_d;
   logic [DUR_W-1:0]     dur_q, dur_d;
   logic [1:0]           wave_q, wave_d;
   logic [2:0]           vol_q, vol_d;
   logic [7:0]           sample_q, sample_d;
   logic                 stb_q, stb_d;

   logic                 tick_w;
   logic [7:0]           p_w;
   logic [7:0]           shape_w;
   logic signed [8:0]    dev_w;
   logic signed [8:0]    att_w;
   logic [7:0]           vol_out_w;

   assign tick_w = (state_q == ST_PLAY) && (div_q == DIV_LAST);
   assign p_w    = phase_q[PHASE_W-1 -: 8];

   always_comb begin
      shape_w = MIDSCALE;
      case (wave_q)
         2'b00:   shape_w = p_w[7] ? 8'd255 : 8'd0;
         2'b01:   shape_w = p_w;
         2'b10:   shape_w = p_w[7] ? ~{p_w[6:0], 1'b0} : {p_w[6:0], 1'b0};
         default: shape_w = MIDSCALE;
      endcase
   end

   // Attenuate the deviation from midscale; the arithmetic shift keeps the result in 0..255.
   assign dev_w     = $signed({1'b0, shape_w}) - 9'sd128;
   assign att_w     = dev_w >>> vol_q;
   assign vol_out_w = 8'(att_w + 9'sd128);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      phase_d    = phase_q;
      inc_d      = inc_q;
      dur_d      = dur_q;
      wave_d     = wave_q;
      vol_d      = vol_q;
      sample_d   = sample_q;
      stb_d      = 1'b0;
      note_ready = 1'b0;
      enable     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            note_ready = 1'b1;
            sample_d   = MIDSCALE;
            if (note_valid) begin
               inc_d   = note_inc;
               wave_d  = note_wave;
               vol_d   = note_vol;
               dur_d   = (note_dur == '0) ? DUR_W'(1) : note_dur;
               phase_d = '0;
               div_d   = '0;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            enable = 1'b1;
            if (tick_w) begin
               div_d    = '0;
               sample_d = vol_out_w;
               stb_d    = 1'b1;
               phase_d  = phase_q + inc_q;
               dur_d    = dur_q - DUR_W'(1);
               if (dur_q == DUR_W'(1)) begin
                  state_d = ST_LAST;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_LAST: begin
            enable   = 1'b1;
            sample_d = MIDSCALE;
            state_d  = ST_IDLE;
         end
         default: begin
            sample_d = MIDSCALE;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pwmclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         phase_q  <= '0;
         inc_q    <= '0;
         dur_q    <= '0;
         wave_q   <= 2'b11;
         vol_q    <= '0;
         sample_q <= MIDSCALE;
         stb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         phase_q  <= phase_d;
         inc_q    <= inc_d;
         dur_q    <= dur_d;
         wave_q   <= wave_d;
         vol_q    <= vol_d;
         sample_q <= sample_d;
         stb_q    <= stb_d;
      end
   end

   assign sample     = sample_q;
   assign sample_stb = stb_q;

endmodule

// File: tb/tb_beep_tone_gen.sv
// tb/tb_beep_tone_gen.sv - self-checking bench for beep_tone_gen
module tb_beep_tone_gen;

   localparam int CLK_DIV = 10;

   logic        pwmclk = 1'b0;
   logic        rst_n;
   logic        note_valid;
   logic        note_ready;
   logic [15:0] note_inc;
   logic [15:0] note_dur;
   logic [1:0]  note_wave;
   logic [2:0]  note_vol;
   logic [7:0]  sample;
   logic        sample_stb;
   logic        enable;

   int errors = 0;
   int checks = 0;

   beep_tone_gen #(.CLK_DIV(CLK_DIV), .PHASE_W(16), .DUR_W(16)) dut (
      .pwmclk     (pwmclk),
      .rst_n      (rst_n),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_inc   (note_inc),
      .note_dur   (note_dur),
      .note_wave  (note_wave),
      .note_vol   (note_vol),
      .sample     (sample),
      .sample_stb (sample_stb),
      .enable     (enable)
   );

   always #5 pwmclk = ~pwmclk;

   // Reference: k-th sample of a note from the waveform definition with plain integer arithmetic.
   function automatic int model_sample(input logic [15:0] inc, input int k,
                                       input logic [1:0] wave, input logic [2:0] vol);
      int ph, p, s, d, q;
      ph = (k * int'(inc)) % 65536;
      p  = ph / 256;
      q  = 1 << int'(vol);
      case (wave)
         2'b00:   s = (p >= 128) ? 255 : 0;
         2'b01:   s = p;
         2'b10:   s = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
         default: s = 128;
      endcase
      d = s - 128;
      if (d >= 0) d = d / q;
      else        d = -((-d + q - 1) / q);
      return 128 + d;
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (note_ready !== 1'b1 && n < 200) begin
         @(posedge pwmclk); #1;
         n++;
      end
      if (note_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: note_ready=%b required 1", name, note_ready);
      end
   endtask

   task automatic test_note(input string name, input logic [15:0] inc, input logic [15:0] dur,
                            input logic [1:0] wave, input logic [2:0] vol);
      int n, stray, en_bad, k, exp;
      n      = (dur == 0) ? 1 : int'(dur);
      stray  = 0;
      en_bad = 0;
      k      = 0;
      wait_ready(name);
      note_valid = 1'b1;
      note_inc   = inc;
      note_dur   = dur;
      note_wave  = wave;
      note_vol   = vol;
      @(posedge pwmclk); #1;
      note_valid = 1'b0;
      checks++;
      if (enable !== 1'b1 || note_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: enable=%b note_ready=%b required 1/0", name, enable, note_ready);
      end
      for (int c = 1; c <= CLK_DIV * n + 1; c++) begin
         @(posedge pwmclk); #1;
         if (c % CLK_DIV == 0 && c <= CLK_DIV * n) begin
            exp = model_sample(inc, k, wave, vol);
            checks++;
            if (sample_stb !== 1'b1 || int'(sample) != exp) begin
               errors++;
               $display("FAIL %s strobe%0d: stb=%b sample=%0d required 1/%0d", name, k, sample_stb, sample, exp);
            end
            k++;
         end else if (sample_stb !== 1'b0) begin
            stray++;
         end
         if (c <= CLK_DIV * n && enable !== 1'b1) en_bad++;
         if (c == CLK_DIV * n + 1) begin
            checks++;
            if (enable !== 1'b0 || note_ready !== 1'b1 || sample !== 8'd128) begin
               errors++;
               $display("FAIL %s end: enable=%b note_ready=%b sample=%0d required 0/1/128", name, enable, note_ready, sample);
            end
         end
      end
      checks++;
      if (stray != 0 || en_bad != 0) begin
         errors++;
         $display("FAIL %s framing: stray_strobes=%0d enable_drops=%0d required 0/0", name, stray, en_bad);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b1;
      note_valid = 1'b0;
      note_inc   = '0;
      note_dur   = '0;
      note_wave  = '0;
      note_vol   = '0;
      #23;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sample !== 8'd128 || enable !== 1'b0 || sample_stb !== 1'b0) begin
         errors++;
         $display("FAIL reset_assert: sample=%0d enable=%b stb=%b required 128/0/0", sample, enable, sample_stb);
      end
      repeat (3) @(posedge pwmclk);
      #1;
      rst_n = 1'b1;
      @(posedge pwmclk); #1;
      checks++;
      if (note_ready !== 1'b1 || sample !== 8'd128 || enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b sample=%0d enable=%b required 1/128/0", note_ready, sample, enable);
      end
   endtask

   task automatic test_saw();
      test_note("saw", 16'h0100, 16'd4, 2'b01, 3'd0);
   endtask

   task automatic test_square();
      test_note("square_v0", 16'h4000, 16'd4, 2'b00, 3'd0);
      test_note("square_v1", 16'h4000, 16'd4, 2'b00, 3'd1);
      test_note("square_v7", 16'h4000, 16'd4, 2'b00, 3'd7);
   endtask

   task automatic test_triangle();
      test_note("triangle", 16'h2000, 16'd8, 2'b10, 3'd0);
   endtask

   task automatic test_edges();
      test_note("dur_zero", 16'h0100, 16'd0, 2'b01, 3'd0);
      test_note("silence", 16'h1234, 16'd3, 2'b11, 3'd0);
      test_note("wrap", 16'hF000, 16'd3, 2'b01, 3'd0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         test_note($sformatf("rand%0d", i), 16'($urandom), 16'($urandom_range(0, 5)),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      end
   endtask

   task automatic test_back_to_back();
      int scyc[$];
      int ssmp[$];
      int en_low, ready_at, exp, ecyc;
      bit b_taken;
      en_low   = 0;
      ready_at = -1;
      b_taken  = 0;
      wait_ready("b2b");
      note_valid = 1'b1;
      note_inc   = 16'h0100;
      note_dur   = 16'd2;
      note_wave  = 2'b01;
      note_vol   = 3'd0;
      @(posedge pwmclk); #1;
      note_inc  = 16'h4000;
      note_dur  = 16'd3;
      note_wave = 2'b00;
      for (int c = 1; c <= 56; c++) begin
         @(posedge pwmclk); #1;
         if (ready_at >= 0 && !b_taken) begin
            note_valid = 1'b0;
            b_taken    = 1;
         end
         if (sample_stb === 1'b1) begin
            scyc.push_back(c);
            ssmp.push_back(int'(sample));
         end
         if (c <= 52 && enable !== 1'b1) en_low++;
         if (note_ready === 1'b1 && ready_at < 0) ready_at = c;
      end
      note_valid = 1'b0;
      checks++;
      if (en_low != 1) begin
         errors++;
         $display("FAIL b2b_enable_gap: low_cycles=%0d required 1", en_low);
      end
      checks++;
      if (ready_at != 2 * CLK_DIV + 1) begin
         errors++;
         $display("FAIL b2b_ready: ready_cycle=%0d required %0d", ready_at, 2 * CLK_DIV + 1);
      end
      checks++;
      if (scyc.size() != 5) begin
         errors++;
         $display("FAIL b2b_count: strobes=%0d required 5", scyc.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (k < 2) begin
               ecyc = CLK_DIV * (k + 1);
               exp  = model_sample(16'h0100, k, 2'b01, 3'd0);
            end else begin
               ecyc = 2 * CLK_DIV + 2 + CLK_DIV * (k - 1);
               exp  = model_sample(16'h4000, k - 2, 2'b00, 3'd0);
            end
            checks++;
            if (scyc[k] != ecyc || ssmp[k] != exp) begin
               errors++;
               $display("FAIL b2b_strobe%0d: cycle=%0d sample=%0d required %0d/%0d", k, scyc[k], ssmp[k], ecyc, exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid_note();
      int strobes, seen;
      strobes = 0;
      seen    = 0;
      wait_ready("midrst");
      note_valid = 1'b1;
      note_inc   = 16'h0100;
      note_dur   = 16'd8;
      note_wave  = 2'b01;
      note_vol   = 3'd0;
      @(posedge pwmclk); #1;
      note_valid = 1'b0;
      for (int c = 1; c <= 60 && seen < 2; c++) begin
         @(posedge pwmclk); #1;
         if (sample_stb === 1'b1) seen++;
      end
      checks++;
      if (seen != 2) begin
         errors++;
         $display("FAIL midrst_setup: strobes=%0d required 2", seen);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sample !== 8'd128 || enable !== 1'b0 || sample_stb !== 1'b0) begin
         errors++;
         $display("FAIL midrst_assert: sample=%0d enable=%b stb=%b required 128/0/0", sample, enable, sample_stb);
      end
      @(posedge pwmclk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(posedge pwmclk); #1;
         if (sample_stb === 1'b1 || enable !== 1'b0) strobes++;
      end
      checks++;
      if (strobes != 0 || note_ready !== 1'b1 || sample !== 8'd128) begin
         errors++;
         $display("FAIL midrst_after: activity=%0d ready=%b sample=%0d required 0/1/128", strobes, note_ready, sample);
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_square();
      test_triangle();
      test_edges();
      test_back_to_back();
      test_random();
      test_reset_mid_note();
      test_saw();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
